paddle_input_conditioner: RTL
=============================

# paddle_input_conditioner

Conditions the four raw paddle push-button lines (player 1 up/down, player 2 up/down) before they reach the speedPong game core. It synchronises each line to CLOCK_50, debounces it and produces clean levels, one-cycle press pulses and paddle-move pulses with optional hold-to-repeat. It sits between the board GPIO pins and the game logic's paddle inputs.

## Interface
- SYNC_STAGES, 2, synchroniser flip-flop depth; legal values are 2 or greater.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a change (10 ms at 50 MHz); minimum 2.
- REPEAT_DELAY, 15000000, cycles from accepted press to first repeat move pulse (300 ms).
- REPEAT_PERIOD, 2500000, cycles between subsequent repeat move pulses (50 ms).
- Counter widths are $clog2 of the largest count parameter.
- CLOCK_50  input  1  system clock, 50 MHz.
- RESET_N  input  1  reset; synchronous, active-low.
- btn_raw_n  input  4  raw buttons, active-low, asynchronous to CLOCK_50; [0]=P1 up, [1]=P1 down, [2]=P2 up, [3]=P2 down.
- btn_level  output  4  debounced level, 1 = pressed.
- btn_press  output  4  one-cycle pulse on each accepted press.
- btn_move  output  4  one-cycle move pulse (press plus repeats), after pair conflict masking.

## Operation
- **Synchroniser**
  - Each channel passes ~btn_raw_n through a SYNC_STAGES flip-flop chain.
  - The synchroniser output is called s.
- **Debounce (per channel)**
  - Registers: stable level L and counter C.
  - If s == L, C clears to 0.
  - Otherwise C increments. When C reaches DEBOUNCE_CYCLES-1 while s != L, L toggles and C clears.
  - Any glitch back to s == L before the threshold restarts the count from 0.
  - btn_level = L, registered.
- **Press detect**
  - btn_press[i] is 1 in exactly the cycle where L[i] first reads 1 after being 0.
  - A release produces no pulse.
- **Repeat FSM (per channel)**
  - States: IDLE, DELAY, REPEAT.
  - IDLE → DELAY on a press. A move request is raised in that same cycle and repeat counter R clears.
  - DELAY: R increments. When R == REPEAT_DELAY-1, raise a move request, clear R and go to REPEAT.
  - REPEAT: R increments. When R == REPEAT_PERIOD-1, raise a move request and clear R.
  - In any state, L = 0 forces IDLE and R = 0 in the following cycle; no request is raised that cycle.
- **Pair conflict**
  - Pairs are {0,1} and {2,3}.
  - If both levels of a pair are 1, btn_move for both channels of that pair is 0. The FSMs keep running, so timing resumes unperturbed when one button is released.
  - Otherwise btn_move[i] equals the move request of channel i.
- **Reset (RESET_N = 0 at a clock edge)**
  - All synchroniser flops, L, C, R clear to 0; FSMs go to IDLE; all outputs are 0.
  - Reset mid-press: after release of reset, the held button must re-qualify through the full synchroniser and debounce path, then produces a normal press.
  - Reset mid-operation discards any partial count.

## Timing
- All outputs are registered; no combinational path from btn_raw_n to any output.
- Latency: s changes SYNC_STAGES cycles after a raw change is sampled.
- L, btn_press and the first btn_move all assert on the same edge, DEBOUNCE_CYCLES cycles after s changes.
- The first repeat pulse follows the press pulse by REPEAT_DELAY cycles; later repeat pulses are spaced REPEAT_PERIOD cycles apart.
- Release: L falls DEBOUNCE_CYCLES cycles after s falls; no move pulse occurs at or after that cycle.
- btn_press and btn_move are exactly 1 cycle wide. Channels operate independently apart from conflict masking.

## Configuration
- Macro: PADDLE_AUTO_REPEAT_EN.
- Defined: the repeat FSM operates as described above.
- Undefined:
  - The repeat FSM and R are not built.
  - btn_move = btn_press with conflict masking; one move per press regardless of hold time.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.

## Test plan
Parameters for all scenarios: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- **Reset:** RESET_N low for 3 cycles with btn_raw_n=4'b0000 → all outputs 0 throughout.
  - After reset release: btn_level=4'b1111 exactly 2+4 cycles later.
  - btn_press=4'b1111 and btn_move=4'b1111 for that single cycle.
- **Bounce:** btn_raw_n[0] toggles low/high every 2 cycles for 20 cycles, then stays high → btn_level[0], btn_press[0] and btn_move[0] never assert.
- **Clean press and hold (macro defined):** btn_raw_n[2] held low for 40 cycles.
  - btn_press[2] asserts once.
  - btn_move[2] pulses at press cycle P, then P+10, P+13, P+16, …
  - btn_level[2] falls 6 cycles after release, and no move pulse occurs from that cycle on.
- **Pair conflict:** hold btn_raw_n[0] low. 5 cycles after btn_level[0] rises, also hold btn_raw_n[1] low.
  - btn_move[1:0] = 0 while both levels are 1.
  - Release [1] → btn_move[0] pulses resume on channel 0's unchanged repeat grid.
- **Macro undefined:** the hold from the clean press-and-hold scenario → exactly one btn_move[2] pulse, coincident with btn_press[2].
- **Reset mid-hold:** RESET_N low for 1 cycle while btn_level[3]=1 and the button is still held → outputs 0.
  - A new btn_press[3] pulse occurs 6 cycles after reset release.

Source files
------------

// File: rtl/paddle_input_conditioner.sv
// paddle_input_conditioner
// Synchronises, debounces and conditions the four active-low paddle buttons
// (P1 up/down, P2 up/down) into clean levels, press pulses and move pulses.
// Optional hold-to-repeat is built when PADDLE_AUTO_REPEAT_EN is defined;
// without it every accepted press yields exactly one move pulse.
//
// Pair lockout: while both buttons of a pair read pressed, that pair's move
// pulses are suppressed. A pair whose two buttons are accepted on the very
// same edge still gets the move from that press; the lockout applies from
// then on. The repeat timers keep running underneath the lockout.
//
// Move requests and the lockout look at the level that is being registered
// on the same edge, so a move pulse never appears alongside a level of 0.
module paddle_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] btn_raw_n,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_move
);

  // One counter width covers the largest count parameter.
  localparam int MAX_DR    = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_COUNT = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CW        = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    s;
  logic [3:0]    lvl;
  logic [3:0]    lvl_next;
  logic [3:0]    db_hit;
  logic [CW-1:0] db_cnt [4];
  logic [3:0]    press_next;
  logic          pair01_lock;
  logic          pair23_lock;
  logic [3:0]    lock;

  // Synchroniser chain on the inverted (active-high) raw buttons.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= ~btn_raw_n;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce decision: toggle the stable level once the mismatch has lasted long enough.
  always_comb begin
    db_hit   = '0;
    lvl_next = lvl;
    for (int i = 0; i < 4; i++) begin
      db_hit[i]   = (s[i] != lvl[i]) && (db_cnt[i] == DB_LAST);
      lvl_next[i] = lvl[i] ^ db_hit[i];
    end
  end

  // Debounce state: any return to the stable level restarts the count.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      lvl <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      lvl <= lvl_next;
      for (int i = 0; i < 4; i++) begin
        if ((s[i] == lvl[i]) || db_hit[i]) db_cnt[i] <= '0;
        else                               db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end

  assign btn_level  = lvl;
  assign press_next = lvl_next & ~lvl;

  // Lock a pair while both levels are 1, except on the edge where both rise together.
  assign pair01_lock = lvl_next[0] & lvl_next[1] & (lvl[0] | lvl[1]);
  assign pair23_lock = lvl_next[2] & lvl_next[3] & (lvl[2] | lvl[3]);
  assign lock        = {pair23_lock, pair23_lock, pair01_lock, pair01_lock};

  // Press pulse registered on the same edge that raises the level.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) btn_press <= '0;
    else          btn_press <= press_next;
  end

`ifdef PADDLE_AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;

  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  rpt_state_e    rpt_state [4];
  logic [CW-1:0] rpt_cnt   [4];

  // Per-channel repeat FSM with registered, lock-masked move pulses.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      btn_move <= '0;
      for (int i = 0; i < 4; i++) begin
        rpt_state[i] <= IDLE;
        rpt_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!lvl_next[i]) begin
          rpt_state[i] <= IDLE;
          rpt_cnt[i]   <= '0;
          btn_move[i]  <= 1'b0;
        end else begin
          case (rpt_state[i])
            IDLE: begin
              rpt_cnt[i]  <= '0;
              btn_move[i] <= press_next[i] & ~lock[i];
              if (press_next[i]) rpt_state[i] <= DELAY;
            end
            DELAY: begin
              if (rpt_cnt[i] == RD_LAST) begin
                rpt_cnt[i]   <= '0;
                btn_move[i]  <= ~lock[i];
                rpt_state[i] <= REPEAT;
              end else begin
                rpt_cnt[i]  <= rpt_cnt[i] + 1'b1;
                btn_move[i] <= 1'b0;
              end
            end
            REPEAT: begin
              if (rpt_cnt[i] == RP_LAST) begin
                rpt_cnt[i]  <= '0;
                btn_move[i] <= ~lock[i];
              end else begin
                rpt_cnt[i]  <= rpt_cnt[i] + 1'b1;
                btn_move[i] <= 1'b0;
              end
            end
            default: begin
              rpt_state[i] <= IDLE;
              rpt_cnt[i]   <= '0;
              btn_move[i]  <= 1'b0;
            end
          endcase
        end
      end
    end
  end
`else
  // One move per accepted press, masked by the pair lockout.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) btn_move <= '0;
    else          btn_move <= press_next & ~lock;
  end
`endif

endmodule
